vm_purchase_driver: RTL and testbench



---
 rtl/vm_pkg.sv | 51 +++++
 rtl/vm_coin_splitter.sv | 43 ++++
 rtl/vm_purchase_driver.sv | 236 +++++++++++++++++++++++
 tb/tb_vm_purchase_driver.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared encodings for the vending-machine purchase driver.
// Holds coin, machine status, response code and FSM state types plus coin values.
package vm_pkg;

  localparam int NUM_ITEMS_DEF = 6;

  localparam int COIN_VAL_5  = 5;
  localparam int COIN_VAL_10 = 10;
  localparam int COIN_VAL_25 = 25;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    VM_BUSY    = 2'b00,
    VM_DISP    = 2'b01,
    VM_INSUFF  = 2'b10,
    VM_NOSTOCK = 2'b11
  } vm_status_e;

  typedef enum logic [2:0] {
    RC_OK       = 3'd0,
    RC_INSUFF   = 3'd1,
    RC_NOSTOCK  = 3'd2,
    RC_TIMEOUT  = 3'd3,
    RC_BAD_ITEM = 3'd4
  } resp_code_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COIN   = 3'd1,
    S_SELECT = 3'd2,
    S_ENTER  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } drv_state_e;

  // Only meaningful for a nonzero status.
  function automatic resp_code_e status_to_code(vm_status_e s);
    case (s)
      VM_INSUFF:  return RC_INSUFF;
      VM_NOSTOCK: return RC_NOSTOCK;
      default:    return RC_OK;
    endcase
  endfunction

endpackage

// File: rtl/vm_coin_splitter.sv
// vm_coin_splitter: one greedy step of the coin breakdown (combinational).
// Ports: rem in; coin = largest coin <= rem, next_rem = rem - coin, done = rem < 5.
module vm_coin_splitter
  import vm_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic [AMT_W-1:0] rem,
  output logic [1:0]       coin,
  output logic [AMT_W-1:0] next_rem,
  output logic             done
);

  logic ge25;
  logic ge10;
  logic ge5;

  assign ge25 = rem >= AMT_W'(COIN_VAL_25);
  assign ge10 = rem >= AMT_W'(COIN_VAL_10);
  assign ge5  = rem >= AMT_W'(COIN_VAL_5);

  always_comb begin
    coin     = COIN_NONE;
    next_rem = rem;
    done     = 1'b0;
    unique case (1'b1)
      ge25: begin
        coin     = COIN_25;
        next_rem = rem - AMT_W'(COIN_VAL_25);
      end
      (ge10 && !ge25): begin
        coin     = COIN_10;
        next_rem = rem - AMT_W'(COIN_VAL_10);
      end
      (ge5 && !ge10): begin
        coin     = COIN_5;
        next_rem = rem - AMT_W'(COIN_VAL_5);
      end
      default: done = 1'b1;
    endcase
  end

endmodule

// File: rtl/vm_purchase_driver.sv
// vm_purchase_driver: customer-side initiator; turns a purchase request into coins,
// a button press and an enter pulse, then returns the machine's answer.
// Ports: req_* (valid/ready request), coins/button/enter_key (to machine),
// product/status/balance (from machine), resp_* (valid/ready response).
// Optional: define VM_DRV_STATS_EN to add saturating stat_ok/stat_fail counters.
module vm_purchase_driver
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS   = NUM_ITEMS_DEF,
  parameter int TIMEOUT_CYC = 64,
  parameter int AMT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_item,
  input  logic [AMT_W-1:0]     req_amount,
  output logic [1:0]           coins,
  output logic [NUM_ITEMS-1:0] button,
  output logic                 enter_key,
  input  logic [2:0]           product,
  input  logic [1:0]           status,
  input  logic [AMT_W-1:0]     balance,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_code,
  output logic [2:0]           resp_product,
  output logic [AMT_W-1:0]     resp_change,
  output logic [AMT_W-1:0]     resp_coins
`ifdef VM_DRV_STATS_EN
  ,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_fail
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  drv_state_e           state_q, state_d;
  logic [2:0]           item_q, item_d;
  logic [AMT_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic [1:0]           coins_q, coins_d;
  logic [NUM_ITEMS-1:0] button_q, button_d;
  logic                 enter_q, enter_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [2:0]           resp_code_q, resp_code_d;
  logic [2:0]           resp_product_q, resp_product_d;
  logic [AMT_W-1:0]     resp_change_q, resp_change_d;
  logic [AMT_W-1:0]     resp_coins_q, resp_coins_d;
`ifdef VM_DRV_STATS_EN
  logic [15:0]          stat_ok_q, stat_ok_d;
  logic [15:0]          stat_fail_q, stat_fail_d;
`endif

  logic [AMT_W-1:0]     split_in;
  logic [1:0]           split_coin;
  logic [AMT_W-1:0]     split_rem;
  logic                 split_done;
  logic                 bad_item;

  // In IDLE the first coin is computed straight from the request, so the
  // first coin is on the wire in the first COIN cycle.
  assign split_in = (state_q == S_IDLE) ? req_amount : rem_q;
  assign bad_item = 32'(req_item) >= NUM_ITEMS;

  vm_coin_splitter #(
    .AMT_W(AMT_W)
  ) u_split (
    .rem     (split_in),
    .coin    (split_coin),
    .next_rem(split_rem),
    .done    (split_done)
  );

  always_comb begin
    state_d        = state_q;
    item_d         = item_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    req_ready_d    = req_ready_q;
    coins_d        = coins_q;
    button_d       = button_q;
    enter_d        = enter_q;
    resp_valid_d   = resp_valid_q;
    resp_code_d    = resp_code_q;
    resp_product_d = resp_product_q;
    resp_change_d  = resp_change_q;
    resp_coins_d   = resp_coins_q;
`ifdef VM_DRV_STATS_EN
    stat_ok_d      = stat_ok_q;
    stat_fail_d    = stat_fail_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          item_d         = req_item;
          req_ready_d    = 1'b0;
          resp_code_d    = RC_OK;
          resp_product_d = '0;
          resp_change_d  = '0;
          resp_coins_d   = '0;
          rem_d          = req_amount;
          if (bad_item) begin
            resp_code_d  = RC_BAD_ITEM;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            coins_d = split_coin;
            rem_d   = split_rem;
            if (!split_done) begin
              resp_coins_d = AMT_W'(1);
            end
            state_d = S_COIN;
          end
        end
      end
      S_COIN: begin
        if (split_done) begin
          coins_d  = COIN_NONE;
          button_d = NUM_ITEMS'(1) << item_q;
          state_d  = S_SELECT;
        end else begin
          coins_d      = split_coin;
          rem_d        = split_rem;
          resp_coins_d = resp_coins_q + AMT_W'(1);
        end
      end
      S_SELECT: begin
        button_d = '0;
        enter_d  = 1'b1;
        state_d  = S_ENTER;
      end
      S_ENTER: begin
        enter_d = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A status arriving on the last counted cycle still wins.
        if (status != VM_BUSY) begin
          resp_code_d    = status_to_code(vm_status_e'(status));
          resp_product_d = product;
          resp_change_d  = balance;
          resp_valid_d   = 1'b1;
          state_d        = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_code_d    = RC_TIMEOUT;
          resp_product_d = '0;
          resp_change_d  = '0;
          resp_valid_d   = 1'b1;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
`ifdef VM_DRV_STATS_EN
          if (resp_code_q == RC_OK) begin
            if (stat_ok_q != 16'hFFFF) begin
              stat_ok_d = stat_ok_q + 16'd1;
            end
          end else if (stat_fail_q != 16'hFFFF) begin
            stat_fail_d = stat_fail_q + 16'd1;
          end
`endif
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      item_q         <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      coins_q        <= COIN_NONE;
      button_q       <= '0;
      enter_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_code_q    <= RC_OK;
      resp_product_q <= '0;
      resp_change_q  <= '0;
      resp_coins_q   <= '0;
`ifdef VM_DRV_STATS_EN
      stat_ok_q      <= '0;
      stat_fail_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      item_q         <= item_d;
      rem_q          <= rem_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      coins_q        <= coins_d;
      button_q       <= button_d;
      enter_q        <= enter_d;
      resp_valid_q   <= resp_valid_d;
      resp_code_q    <= resp_code_d;
      resp_product_q <= resp_product_d;
      resp_change_q  <= resp_change_d;
      resp_coins_q   <= resp_coins_d;
`ifdef VM_DRV_STATS_EN
      stat_ok_q      <= stat_ok_d;
      stat_fail_q    <= stat_fail_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign coins        = coins_q;
  assign button       = button_q;
  assign enter_key    = enter_q;
  assign resp_valid   = resp_valid_q;
  assign resp_code    = resp_code_q;
  assign resp_product = resp_product_q;
  assign resp_change  = resp_change_q;
  assign resp_coins   = resp_coins_q;
`ifdef VM_DRV_STATS_EN
  assign stat_ok      = stat_ok_q;
  assign stat_fail    = stat_fail_q;
`endif

endmodule

// File: tb/tb_vm_purchase_driver.sv
// tb_vm_purchase_driver: directed bench with a cycle-level expectation model.
// Drives purchases against a small machine model and checks every cycle.
module tb_vm_purchase_driver;

  localparam int NI = 6;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_item = '0;
  logic [15:0] req_amount = '0;
  logic [1:0]  coins;
  logic [5:0]  button;
  logic        enter_key;
  logic [2:0]  product = '0;
  logic [1:0]  status = '0;
  logic [15:0] balance = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [2:0]  resp_code;
  logic [2:0]  resp_product;
  logic [15:0] resp_change;
  logic [15:0] resp_coins;
`ifdef VM_DRV_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_fail;
`endif

  vm_purchase_driver #(
    .NUM_ITEMS  (NI),
    .TIMEOUT_CYC(TO),
    .AMT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_item    (req_item),
    .req_amount  (req_amount),
    .coins       (coins),
    .button      (button),
    .enter_key   (enter_key),
    .product     (product),
    .status      (status),
    .balance     (balance),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_code   (resp_code),
    .resp_product(resp_product),
    .resp_change (resp_change),
    .resp_coins  (resp_coins)
`ifdef VM_DRV_STATS_EN
    ,
    .stat_ok     (stat_ok),
    .stat_fail   (stat_fail)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Machine model parameters: respond m_k cycles after enter (0 = never).
  int m_k = 0;
  int m_st = 0;
  int m_pr = 0;
  int m_bal = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (enter_key === 1'b1 && m_k > 0) begin
        repeat (m_k) @(posedge clk);
        #1;
        status  = 2'(m_st);
        product = 3'(m_pr);
        balance = 16'(m_bal);
        @(posedge clk);
        #1;
        status  = 2'b00;
        product = 3'd0;
        balance = 16'd0;
      end
    end
  end

  // Expected outputs per busy cycle, built from the purchase rules.
  typedef struct packed {
    logic [1:0] c;
    logic [5:0] b;
    logic       e;
  } cyc_t;

  cyc_t exp_q[$];
  int e_code, e_prod, e_chg, e_ncoin;
  int ph = 0;
  bit chk_en = 1'b0;
  logic [31:0] coin_word = '0;
  logic [5:0] btn_or = '0;
  int enter_cnt = 0;

  function automatic void build(int item, int amt, int k, int st,
                                int pr, int bal);
    int n25, n10, n5, r, w;
    cyc_t z;
    cyc_t x;
    exp_q.delete();
    z = '0;
    if (item >= NI) begin
      e_code = 4; e_prod = 0; e_chg = 0; e_ncoin = 0;
      return;
    end
    n25 = amt / 25;
    r = amt % 25;
    n10 = r / 10;
    r = r % 10;
    n5 = r / 5;
    x = z; x.c = 2'b11; repeat (n25) exp_q.push_back(x);
    x = z; x.c = 2'b10; repeat (n10) exp_q.push_back(x);
    x = z; x.c = 2'b01; repeat (n5) exp_q.push_back(x);
    if (n25 + n10 + n5 == 0) exp_q.push_back(z);
    x = z; x.b = 6'(1 << item); exp_q.push_back(x);
    x = z; x.e = 1'b1; exp_q.push_back(x);
    if (k > 0 && k <= TO) begin
      w = k; e_code = st - 1; e_prod = pr; e_chg = bal;
    end else begin
      w = TO; e_code = 3; e_prod = 0; e_chg = 0;
    end
    repeat (w) exp_q.push_back(z);
    e_ncoin = n25 + n10 + n5;
  endfunction

  always @(negedge clk) begin : cmp
    cyc_t e;
    if (chk_en) begin
      if (coins != 2'b00) coin_word = {coin_word[29:0], coins};
      btn_or = btn_or | button;
      enter_cnt += int'(enter_key);
      if (ph == 0) begin
        chk("idle_ready", 32'(req_ready), 1);
        chk("idle_valid", 32'(resp_valid), 0);
        chk("idle_coins", 32'(coins), 0);
        chk("idle_button", 32'(button), 0);
        chk("idle_enter", 32'(enter_key), 0);
      end else if (ph == 1) begin
        e = exp_q.pop_front();
        chk("busy_ready", 32'(req_ready), 0);
        chk("busy_valid", 32'(resp_valid), 0);
        chk("coins", 32'(coins), 32'(e.c));
        chk("button", 32'(button), 32'(e.b));
        chk("enter", 32'(enter_key), 32'(e.e));
      end else begin
        chk("done_valid", 32'(resp_valid), 1);
        chk("done_ready", 32'(req_ready), 0);
        chk("done_code", 32'(resp_code), e_code);
        chk("done_product", 32'(resp_product), e_prod);
        chk("done_change", 32'(resp_change), e_chg);
        chk("done_ncoins", 32'(resp_coins), e_ncoin);
        chk("done_quiet", {coins, button, enter_key}, 0);
      end
      if (!rst) begin
        ph = 0;
        exp_q.delete();
      end else if (ph == 0 && req_valid) begin
        build(int'(req_item), int'(req_amount), m_k, m_st, m_pr, m_bal);
        coin_word = '0;
        btn_or = '0;
        enter_cnt = 0;
        ph = (exp_q.size() > 0) ? 1 : 2;
      end else if (ph == 1 && exp_q.size() == 0) begin
        ph = 2;
      end else if (ph == 2 && resp_ready) begin
        ph = 0;
      end
    end
  end

  int r_code, r_prod, r_chg, r_coins;

  task automatic run_txn(input int item, input int amt, input int k,
                         input int st, input int pr, input int bal,
                         input int hold, input bit poke, output int lat);
    m_k = k; m_st = st; m_pr = pr; m_bal = bal;
    if (hold < 0) resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_item = 3'(item);
    req_amount = 16'(amt);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i < 200 && lat < 0; i++) begin
      @(negedge clk);
      if (resp_valid) lat = i;
      else begin
        @(posedge clk); #1;
      end
    end
    if (lat < 0) begin
      chk("resp_wait_expired", 0, 1);
    end else begin
      r_code = int'(resp_code);
      r_prod = int'(resp_product);
      r_chg = int'(resp_change);
      r_coins = int'(resp_coins);
      if (hold >= 0) begin
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          if (poke) begin
            req_valid = 1'b1; req_item = 3'd0; req_amount = 16'd5;
          end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  int lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_outs", {coins, button, enter_key, resp_valid}, 0);
    chk("rst_resp", {resp_code, resp_product, resp_change, resp_coins}, 0);

    run_txn(2, 40, 3, 1, 2, 15, 0, 1'b0, lat);
    chk("t40_lat", lat, 9);
    chk("t40_code", r_code, 0);
    chk("t40_prod", r_prod, 2);
    chk("t40_chg", r_chg, 15);
    chk("t40_ncoin", r_coins, 3);
    chk("t40_coinseq", coin_word, 32'h39);
    chk("t40_button", 32'(btn_or), 32'h04);
    chk("t40_enters", enter_cnt, 1);

    run_txn(1, 7, 2, 2, 1, 7, 0, 1'b0, lat);
    chk("t7_code", r_code, 1);
    chk("t7_ncoin", r_coins, 1);
    chk("t7_coinseq", coin_word, 32'h1);

    run_txn(6, 30, 2, 1, 0, 0, 0, 1'b0, lat);
    chk("bad_lat", lat, 1);
    chk("bad_code", r_code, 4);
    chk("bad_quiet", {coin_word, 26'(btn_or), 32'(enter_cnt)}, 0);

    run_txn(0, 10, 0, 0, 0, 0, 0, 1'b0, lat);
    chk("to_lat", lat, 68);
    chk("to_code", r_code, 3);
    chk("to_chg", r_chg, 0);

    run_txn(5, 0, 64, 3, 5, 0, 0, 1'b0, lat);
    chk("edge_lat", lat, 68);
    chk("edge_code", r_code, 2);
    chk("edge_prod", r_prod, 5);
    chk("edge_ncoin", r_coins, 0);

    m_k = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_item = 3'd1; req_amount = 16'd75;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_coins", 32'(coins), 0);
    chk("mrst_valid", 32'(resp_valid), 0);
    chk("mrst_ready", 32'(req_ready), 1);
    run_txn(3, 25, 1, 1, 3, 0, 0, 1'b0, lat);
    chk("mrst_lat", lat, 5);
    chk("mrst_code", r_code, 0);
    chk("mrst_ncoin", r_coins, 1);

    run_txn(4, 55, 2, 1, 4, 5, 10, 1'b1, lat);
    chk("stall_lat", lat, 8);
    chk("stall_chg", r_chg, 5);
    chk("stall_ncoin", r_coins, 3);

    run_txn(0, 99, 1, 1, 0, 4, -1, 1'b0, lat);
    chk("t99_lat", lat, 9);
    chk("t99_ncoin", r_coins, 5);
    chk("t99_chg", r_chg, 4);
    @(negedge clk);
    chk("t99_idle", {31'(resp_valid), req_ready}, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
